// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the load/store front-end: access sizes, FSM states and
// the alignment check used when MEM_MISALIGN_TRAP_EN is defined.
package mem_access_ctrl_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC  = 2'b01,
    WR   = 2'b10,
    RSP  = 2'b11
  } state_e;

  // Size 2'b11 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = lo[0];
      default: mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Combinational lane logic: extracts and extends load data from a RAM word and
// merges byte/half store data into an old word for read-modify-write.
module mem_lane_unit
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [1:0]        size_i,
  input  logic              uns_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] ld_data_o,
  output logic [DATA_W-1:0] st_word_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select, extension and store merge.
  always_comb begin
    byte_s    = 8'h00;
    ld_data_o = word_i;
    st_word_o = word_i;
    case (addr_lo_i)
      2'b00:   byte_s = word_i[7:0];
      2'b01:   byte_s = word_i[15:8];
      2'b10:   byte_s = word_i[23:16];
      default: byte_s = word_i[31:24];
    endcase
    half_s = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      SIZE_B: begin
        ld_data_o = {{24{byte_s[7] & ~uns_i}}, byte_s};
        case (addr_lo_i)
          2'b00:   st_word_o[7:0]   = wdata_i[7:0];
          2'b01:   st_word_o[15:8]  = wdata_i[7:0];
          2'b10:   st_word_o[23:16] = wdata_i[7:0];
          default: st_word_o[31:24] = wdata_i[7:0];
        endcase
      end
      SIZE_H: begin
        ld_data_o = {{16{half_s[15] & ~uns_i}}, half_s};
        if (addr_lo_i[1]) begin
          st_word_o[31:16] = wdata_i[15:0];
        end else begin
          st_word_o[15:0] = wdata_i[15:0];
        end
      end
      default: begin
        ld_data_o = word_i;
        st_word_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store front-end for a word-only RAM; sub-word stores use read-modify-write.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses via rsp_err_o.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              ram_wr_en_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] old_q, old_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mis_s;
  logic              word_store_s;
  logic [DATA_W-1:0] lane_word_s;
  logic [DATA_W-1:0] ld_data_s;
  logic [DATA_W-1:0] st_word_s;

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis_s = is_misaligned(req_size_i, req_addr_i[1:0]);
`else
  assign mis_s = 1'b0;
`endif

  assign word_store_s = we_q & size_q[1];
  // In WR the lane unit merges into the captured old word; otherwise it sees the live RAM read.
  assign lane_word_s  = (state_q == WR) ? old_q : ram_data_i;

  mem_lane_unit #(.DATA_W(DATA_W)) u_lane (
    .word_i    (lane_word_s),
    .addr_lo_i (addr_q[1:0]),
    .size_i    (size_q),
    .uns_i     (uns_q),
    .wdata_i   (wdata_q),
    .ld_data_o (ld_data_s),
    .st_word_o (st_word_s)
  );

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    old_d   = old_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          rdata_d = {DATA_W{1'b0}};
          state_d = mis_s ? RSP : ACC;
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        if (!we_q) begin
          rdata_d = ld_data_s;
          state_d = RSP;
        end else if (word_store_s) begin
          state_d = RSP;
        end else begin
          old_d   = ram_data_i;
          state_d = WR;
        end
      end
      WR:  state_d = RSP;
      RSP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = RSP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      old_q   <= {DATA_W{1'b0}};
      rdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      old_q   <= old_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic err_q;

  // Error flag captured at request acceptance, held through the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q == IDLE && req_valid_i) begin
      err_q <= mis_s;
    end else begin
      err_q <= err_q;
    end
  end

  assign rsp_err_o = err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  assign req_ready_o = (state_q == IDLE) & ~rst;
  assign rsp_valid_o = (state_q == RSP);
  assign rsp_rdata_o = rdata_q;
  // Write gated by rst so a reset landing in ACC/WR never commits a partial store.
  assign ram_wr_en_o = ~rst & (((state_q == ACC) & word_store_s) | (state_q == WR));
  assign ram_addr_o  = (state_q == IDLE) ? {ADDR_W{1'b0}} : {addr_q[ADDR_W-1:2], 2'b00};

  // RAM write data: full word store in ACC, merged word in WR.
  always_comb begin
    ram_data_o = {DATA_W{1'b0}};
    case (state_q)
      ACC: begin
        if (word_store_s) begin
          ram_data_o = wdata_q;
        end else begin
          ram_data_o = {DATA_W{1'b0}};
        end
      end
      WR:      ram_data_o = st_word_s;
      default: ram_data_o = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store front-end between the core's memory stage and the word-only data RAM (32-bit words, full-word write, combinational read, word index = addr[31:2]).
- Converts byte/half/word loads into lane extraction with sign/zero extension.
- Converts byte/half stores into a read-modify-write sequence, because the RAM has no byte enables.
- Single outstanding request, valid/ready handshake on both the request and response sides.

Parameters:
- ADDR_W, 32, width of request and RAM address.
- DATA_W, 32, data word width; only 32 is supported.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  request accepted when valid & ready.
- req_we_i  input  1  1 = store, 0 = load.
- req_size_i  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_unsigned_i  input  1  zero-extend loads when 1.
- req_addr_i  input  ADDR_W  byte address.
- req_wdata_i  input  DATA_W  store data, right-aligned.
- rsp_valid_o  output  1  response valid.
- rsp_ready_i  input  1  response consumed when valid & ready.
- rsp_rdata_o  output  DATA_W  extended load data; 0 for stores.
- rsp_err_o  output  1  misaligned access (feature only, else tied 0).
- ram_wr_en_o  output  1  RAM write enable.
- ram_addr_o  output  ADDR_W  word-aligned RAM address.
- ram_data_o  output  DATA_W  RAM write data.
- ram_data_i  input  DATA_W  RAM combinational read data.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port rst; it is sampled only on the rising edge of clk.
- Reset values:
  - state = IDLE.
  - rsp_valid_o, rsp_rdata_o, rsp_err_o, ram_wr_en_o, ram_addr_o, ram_data_o all 0.
  - req_ready_o is 0 while rst = 1.
- States:
  - IDLE: req_ready_o = 1. On handshake, latch we, size, unsigned, addr and wdata, then go to ACC.
  - ACC: ram_addr_o = {addr_q[31:2], 2'b00}.
    - Load: extract the lane from ram_data_i, register it into rsp_rdata_o, go to RSP.
    - Word store: ram_wr_en_o = 1, ram_data_o = wdata_q, go to RSP.
    - Byte/half store: capture ram_data_i into old_q, go to WR.
  - WR: ram_wr_en_o = 1, ram_data_o = old_q with the target lane replaced by wdata_q[7:0] or wdata_q[15:0]; go to RSP.
  - RSP: rsp_valid_o = 1, held stable until rsp_ready_i = 1; then go to IDLE. There is no request acceptance in the same cycle as response retirement.
- Lanes:
  - Byte lane = addr[1:0] (lane 0 = bits 7:0).
  - Half lane = addr[1] (lane 0 = bits 15:0); addr[0] is ignored unless the feature is enabled.
  - Loads sign-extend from bit 7 or 15 unless req_unsigned_i = 1.
- Latency (handshake cycle to rsp_valid_o):
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Byte/half store: 3 cycles.
- ram_wr_en_o is asserted for exactly one cycle per store and is 0 in all other states.
- ram_addr_o holds the latched address from ACC through RSP; it is 0 in IDLE.
- Reset mid-operation:
  - Any state returns to IDLE.
  - ram_wr_en_o is gated by !rst, so no partial write occurs.
  - A pending response is dropped.
- req_* inputs are ignored outside IDLE.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - A half access with addr[0] = 1, or a word access with addr[1:0] != 0, skips ACC/WR and goes directly to RSP with rsp_err_o = 1 and rsp_rdata_o = 0.
  - No RAM write occurs.
  - Response latency is 1 cycle.
- Undefined:
  - The low address bits are silently truncated for alignment.
  - rsp_err_o is tied to 0.

Decomposition:
- Shared defines: size encodings (SIZE_B / SIZE_H / SIZE_W) and state encodings.
- One sub-module, mem_lane_unit (combinational). Inputs: word, addr[1:0], size, unsigned, wdata. Outputs: extended load data and merged store word. Instantiated once.

Test Plan:
- Word store then load: store addr 0x10 data 0xDEADBEEF, then load word 0x10 -> one ram_wr_en_o pulse with ram_addr_o = 0x10; rsp_rdata_o = 0xDEADBEEF 2 cycles after the load handshake.
- Byte RMW: RAM[0x20] = 0x11223344; store byte 0xAA at 0x22 -> read in ACC, write 0x11AA3344 in WR, rsp_valid_o 3 cycles after handshake.
- Sign/zero extend: RAM[0x30] = 0x80F0_7F85.
  - Load byte signed at 0x30 -> 0xFFFFFF85.
  - Load byte unsigned at 0x30 -> 0x00000085.
  - Load half signed at 0x32 -> 0xFFFF80F0.
- Backpressure: rsp_ready_i = 0 for 5 cycles -> rsp_valid_o and rsp_rdata_o stable, req_ready_o = 0 throughout.
- Reset in WR: assert rst during a byte-store WR cycle -> no RAM write, RAM word unchanged, outputs at reset values on the next cycle.
- Feature on: load word at 0x42 -> rsp_err_o = 1 after 1 cycle, no RAM write. Feature off: same access reads the word at 0x40.
